// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and baud divisor helper.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick marks the last clock of each DIV-clock bit.
module uart_baud_gen #(
    parameter int unsigned DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign bit_tick = en && (cnt_q == LAST);

    // Count clocks within a bit; wrap at the bit boundary, clear on a new command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= bit_tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Multi-frame UART transmitter: sends a CMD_WIDTH command as back-to-back frames,
// most significant slice first, each slice LSB first.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CMD_WIDTH = 16,
    parameter int unsigned PARITY    = 1,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CMD_WIDTH-1:0] cmd_in,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 cmd_done
);

    localparam int unsigned BAUD_DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned NUM_FRAMES = CMD_WIDTH / DATA_BITS;
    localparam int unsigned BIT_W      = $clog2(DATA_BITS + 1);
    localparam int unsigned FRM_W      = $clog2(NUM_FRAMES + 1);

    if (CMD_WIDTH % DATA_BITS != 0) begin : g_bad_width
        $error("uart_tx_frame: CMD_WIDTH must be a multiple of DATA_BITS");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_tx_frame: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end

    uart_tx_state_t         state_q;
    logic [CMD_WIDTH-1:0]   shreg_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   par_q;
    logic [BIT_W-1:0]       bit_cnt_q;
    logic [FRM_W-1:0]       frame_cnt_q;
    logic                   stop_cnt_q;
    logic                   tx_q;
    logic                   rdy_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   accept;
    logic                   bit_tick;
    logic [DATA_BITS-1:0]   slice;
    logic                   slice_par;

    assign accept    = cmd_vld && rdy_q;
    assign slice     = shreg_q[CMD_WIDTH-1 -: DATA_BITS];
    assign slice_par = (PARITY == PAR_EVEN) ? ^slice : ~^slice;

    assign cmd_rdy  = rdy_q;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign cmd_done = done_q;

    uart_baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .en       (busy_q),
        .bit_tick (bit_tick)
    );

    // Frame FSM: every state change happens on a bit boundary, tx is always registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            data_q      <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            rdy_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        shreg_q     <= cmd_in;
                        frame_cnt_q <= '0;
                        bit_cnt_q   <= '0;
                        tx_q        <= 1'b0;
                        rdy_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (bit_tick) begin
                        // Peel off the top slice; the first data bit goes out now.
                        tx_q      <= slice[0];
                        data_q    <= slice >> 1;
                        par_q     <= slice_par;
                        shreg_q   <= shreg_q << DATA_BITS;
                        bit_cnt_q <= BIT_W'(1);
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == BIT_W'(DATA_BITS)) begin
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= StParity;
                            end else begin
                                tx_q       <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= StStop;
                            end
                        end else begin
                            tx_q      <= data_q[0];
                            data_q    <= data_q >> 1;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                StParity: begin
                    if (bit_tick) begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= StStop;
                    end
                end
                StStop: begin
                    if (bit_tick) begin
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            stop_cnt_q <= 1'b0;
                            bit_cnt_q  <= '0;
                            if (frame_cnt_q == FRM_W'(NUM_FRAMES - 1)) begin
                                frame_cnt_q <= '0;
                                tx_q        <= 1'b1;
                                rdy_q       <= 1'b1;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                state_q     <= StIdle;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + FRM_W'(1);
                                tx_q        <= 1'b0;
                                state_q     <= StStart;
                            end
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                    rdy_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three instances with different parameter sets.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a: 16-bit odd parity 1 stop, DIV 10
    logic [15:0] cmd_a = '0;
    logic        vld_a = 1'b0;
    logic        rdy_a, tx_a, busy_a, done_a;
    // b: 24-bit even parity 2 stop, DIV 10
    logic [23:0] cmd_b = '0;
    logic        vld_b = 1'b0;
    logic        rdy_b, tx_b, busy_b, done_b;
    // c: default clock/baud (DIV 434), 8-bit no parity
    logic [7:0]  cmd_c = '0;
    logic        vld_c = 1'b0;
    logic        rdy_c, tx_c, busy_c, done_c;

    uart_tx_frame #(
        .CLK_FREQ (1000000), .BAUD (100000), .DATA_BITS (8),
        .CMD_WIDTH (16), .PARITY (1), .STOP_BITS (1)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .cmd_in (cmd_a), .cmd_vld (vld_a),
        .cmd_rdy (rdy_a), .tx (tx_a), .tx_busy (busy_a), .cmd_done (done_a)
    );

    uart_tx_frame #(
        .CLK_FREQ (1000000), .BAUD (100000), .DATA_BITS (8),
        .CMD_WIDTH (24), .PARITY (2), .STOP_BITS (2)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .cmd_in (cmd_b), .cmd_vld (vld_b),
        .cmd_rdy (rdy_b), .tx (tx_b), .tx_busy (busy_b), .cmd_done (done_b)
    );

    uart_tx_frame #(
        .CMD_WIDTH (8), .PARITY (0)
    ) dut_c (
        .clk (clk), .rst_n (rst_n), .cmd_in (cmd_c), .cmd_vld (vld_c),
        .cmd_rdy (rdy_c), .tx (tx_c), .tx_busy (busy_c), .cmd_done (done_c)
    );

    int   sel = 0;
    logic cur_tx, cur_rdy, cur_busy, cur_done;

    always_comb begin
        case (sel)
            1: begin
                cur_tx = tx_b; cur_rdy = rdy_b; cur_busy = busy_b; cur_done = done_b;
            end
            2: begin
                cur_tx = tx_c; cur_rdy = rdy_c; cur_busy = busy_c; cur_done = done_c;
            end
            default: begin
                cur_tx = tx_a; cur_rdy = rdy_a; cur_busy = busy_a; cur_done = done_a;
            end
        endcase
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Present a command at a negedge; returns just after the accepting posedge.
    task automatic start_cmd(input int s, input logic [23:0] cmd, input bit hold);
        sel = s;
        @(negedge clk);
        chk("rdy_before_accept", int'(cur_rdy), 1);
        case (s)
            1:       begin cmd_b = cmd;        vld_b = 1'b1; end
            2:       begin cmd_c = cmd[7:0];   vld_c = 1'b1; end
            default: begin cmd_a = cmd[15:0];  vld_a = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if (!hold) begin
            vld_a = 1'b0;
            vld_b = 1'b0;
            vld_c = 1'b0;
        end
    endtask

    // Follow a transfer cycle by cycle from the cycle after accept through the done cycle.
    // line holds the expected bits in transmit order, first bit in position nbits-1.
    task automatic walk(input string nm, input logic [63:0] line, input int nbits,
                        input int div, input int busy_len);
        int n        = nbits * div;
        int bad_line = 0;
        int bad_rdy  = 0;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge clk);
            if (c <= n) begin
                if (cur_tx !== line[nbits - 1 - (c - 1) / div]) bad_line++;
                if (cur_rdy !== 1'b0) bad_rdy++;
            end
            if (cur_busy === 1'b1) busy_cnt++;
            if (cur_done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
        end
        chk({nm, "_line_bad_cycles"}, bad_line, 0);
        chk({nm, "_rdy_low_bad_cycles"}, bad_rdy, 0);
        chk({nm, "_busy_cycles"}, busy_cnt, busy_len);
        chk({nm, "_done_count"}, done_cnt, 1);
        chk({nm, "_done_cycle"}, done_at, n + 1);
        chk({nm, "_rdy_at_done"}, int'(cur_rdy), 1);
        chk({nm, "_tx_idle_at_done"}, int'(cur_tx), 1);
    endtask

    typedef struct {
        string       name;
        int          s;
        logic [23:0] cmd;
        int          nbits;
        int          div;
        logic [63:0] line;
        int          busy_len;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int idle_bad;

        // start | data LSB first | parity | stop(s)
        vecs[0] = '{"a_A55A", 0, 24'h00A55A, 22, 10,
                    64'(22'b0_10100101_1_1_0_01011010_1_1), 220};
        vecs[1] = '{"a_1234", 0, 24'h001234, 22, 10,
                    64'(22'b0_01001000_1_1_0_00101100_0_1), 220};
        vecs[2] = '{"a_0000", 0, 24'h000000, 22, 10,
                    64'(22'b0_00000000_1_1_0_00000000_1_1), 220};
        vecs[3] = '{"a_FF01", 0, 24'h00FF01, 22, 10,
                    64'(22'b0_11111111_1_1_0_10000000_0_1), 220};
        vecs[4] = '{"b_0180FF", 1, 24'h0180FF, 36, 10,
                    64'(36'b0_10000000_1_11_0_00000001_1_11_0_11111111_0_11), 360};
        vecs[5] = '{"b_000003", 1, 24'h000003, 36, 10,
                    64'(36'b0_00000000_0_11_0_00000000_0_11_0_11000000_0_11), 360};
        vecs[6] = '{"c_55_div434", 2, 24'h000055, 10, 434,
                    64'(10'b0_10101010_1), 4340};

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("reset_tx_a", int'(tx_a), 1);
        chk("reset_rdy_a", int'(rdy_a), 1);
        chk("reset_busy_a", int'(busy_a), 0);
        chk("reset_done_a", int'(done_a), 0);
        rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || rdy_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0)
                idle_bad++;
            if (tx_b !== 1'b1 || rdy_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0)
                idle_bad++;
            if (tx_c !== 1'b1 || rdy_c !== 1'b1 || busy_c !== 1'b0 || done_c !== 1'b0)
                idle_bad++;
        end
        chk("idle_100_bad_cycles", idle_bad, 0);

        // Table of single commands
        for (int i = 0; i < 7; i++) begin
            start_cmd(vecs[i].s, vecs[i].cmd, 1'b0);
            walk(vecs[i].name, vecs[i].line, vecs[i].nbits, vecs[i].div, vecs[i].busy_len);
            @(negedge clk);
            chk({vecs[i].name, "_done_clears"}, int'(cur_done), 0);
        end

        // Back-to-back with cmd_vld held; cmd_in changes mid-transfer
        start_cmd(0, 24'h001234, 1'b1);
        fork
            walk("b2b_first", 64'(22'b0_01001000_1_1_0_00101100_0_1), 22, 10, 220);
            begin
                repeat (50) @(negedge clk);
                cmd_a = 16'hFFFF;
            end
        join
        @(posedge clk);
        #1;
        vld_a = 1'b0;
        walk("b2b_second", 64'(22'b0_11111111_1_1_0_11111111_1_1), 22, 10, 220);
        @(negedge clk);
        chk("b2b_done_clears", int'(done_a), 0);
        chk("b2b_no_third_accept", int'(busy_a), 0);

        // Reset during frame-0 data bits
        start_cmd(0, 24'h001234, 1'b0);
        repeat (25) @(negedge clk);
        chk("pre_reset_busy", int'(busy_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", int'(tx_a), 1);
        chk("async_reset_rdy", int'(rdy_a), 1);
        chk("async_reset_busy", int'(busy_a), 0);
        chk("async_reset_done", int'(done_a), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || rdy_a !== 1'b1) idle_bad++;
        end
        chk("post_reset_no_resume", idle_bad, 0);
        start_cmd(0, 24'h0000FF, 1'b0);
        walk("after_reset_00FF", 64'(22'b0_00000000_1_1_0_11111111_1_1), 22, 10, 220);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised multi-byte UART transmitter. It accepts a CMD_WIDTH-bit command over a valid/ready handshake and serialises it as back-to-back UART frames.
- Each frame has a start bit, DATA_BITS data bits, an optional parity bit and 1 or 2 stop bits.
- Generalises the team's fixed 16-bit/115200/odd-parity command transmitter to any width, baud rate, parity mode and stop-bit count, and adds a completion pulse.
- Sits between the command generator and the board-level TX pin.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- DATA_BITS, 8, data bits per frame; legal values 5..8.
- CMD_WIDTH, 16, command width; must be an integer multiple of DATA_BITS. NUM_FRAMES = CMD_WIDTH/DATA_BITS.
- PARITY, 1, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_in  input  CMD_WIDTH  command word; sampled only on accept.
- cmd_vld  input  1  command valid.
- cmd_rdy  output  1  block can accept a command.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high from the cycle after accept until the last stop bit ends.
- cmd_done  output  1  one-cycle pulse when the whole command has been sent.

Behaviour:
- Reset (async, active-low) values: tx=1, cmd_rdy=1, tx_busy=0, cmd_done=0; state=IDLE; all counters 0.
- Reset asserted mid-operation aborts the transfer immediately. tx returns to 1; no partial frame resumes after reset releases.
- BAUD_DIV = (CLK_FREQ + BAUD/2)/BAUD, i.e. integer division rounded to nearest. Default = 434.
- Every bit, including start, parity and stop, lasts exactly BAUD_DIV clocks.
- The baud counter is cleared on accept and at every bit boundary. It counts only while busy.
- Accept occurs when cmd_vld && cmd_rdy on a rising edge. On accept:
  - cmd_in is latched into a shift register;
  - cmd_rdy = 0 and tx_busy = 1 from the next cycle;
  - tx = 0 (start bit) from the next cycle.
- cmd_vld while cmd_rdy = 0 is ignored; no queuing.
- cmd_in changes after accept have no effect.
- Frame order: the most significant DATA_BITS slice goes first (cmd_in[CMD_WIDTH-1 -: DATA_BITS]). Within a frame, data is sent LSB first.
- Parity is computed over the frame's data bits.
  - Odd mode: parity bit = ~^data, so data plus parity has an odd count of ones.
  - Even mode: parity bit = ^data.
  - Mode 0: the PARITY state is skipped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after 1 bit.
  - DATA -> PARITY after DATA_BITS bits, or -> STOP if PARITY = 0.
  - PARITY -> STOP after 1 bit.
  - STOP -> START after STOP_BITS bits if frames remain. There is no idle gap between frames.
  - STOP -> IDLE after STOP_BITS bits on the last frame.
- Counters:
  - bit index counter: $clog2(DATA_BITS+1) bits;
  - frame counter: $clog2(NUM_FRAMES+1) bits;
  - stop counter: 1 bit.
  - The frame counter wraps to 0 on return to IDLE.
- Completion: in the first IDLE cycle after the last stop bit:
  - cmd_done = 1 for exactly one cycle;
  - cmd_rdy = 1 and tx_busy = 0.
- A command may be accepted in that same cycle. Its start bit then begins the next cycle, so the minimum inter-command line idle is 1 clock.
- Command duration: tx_busy is high for NUM_FRAMES*(1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV cycles.
- tx is driven from a register; no combinational path from cmd_in to tx.
- Illegal parameters (CMD_WIDTH % DATA_BITS != 0, STOP_BITS outside 1..2, PARITY > 2) trigger an elaboration-time $error.

Decomposition:
- Shared package uart_pkg contains:
  - localparams PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - state enum typedef uart_tx_state_t;
  - constant function baud_div(clk_freq, baud) with rounding as above, for reuse by a future receiver.
- One natural sub-module: uart_baud_gen. It is a BAUD_DIV-cycle counter with clear and enable, producing a bit_tick pulse on the last cycle of each bit. The frame FSM and shift logic stay in uart_tx_frame.

Test Plan:
- Bench parameters for scenarios 1–4: CLK_FREQ=1000000, BAUD=100000, so BAUD_DIV=10.
- 1. Reset/idle: hold rst_n=0, then release with cmd_vld=0 for 100 cycles -> tx=1, cmd_rdy=1, tx_busy=0, cmd_done=0 throughout.
- 2. Default 16-bit, odd parity: send 0xA55A.
  - Line sequence: 0, 1,0,1,0,0,1,0,1, parity 1, stop 1; then 0, 0,1,0,1,1,0,1,0, parity 1, stop 1.
  - Every bit is 10 clocks wide; tx_busy is high for 220 cycles.
  - cmd_done pulses once at cycle 221 after accept.
- 3. PARITY=2, STOP_BITS=2, CMD_WIDTH=24: send 0x0180FF.
  - Parity bits are 1, 1, 0 respectively.
  - Each frame is 12 bits; tx_busy is high for 360 cycles.
- 4. Back-to-back and ignore:
  - Assert cmd_vld continuously with 0x1234, changing cmd_in to 0xFFFF mid-transfer.
  - Required: second accept occurs exactly in the cmd_done cycle, and tx is high for exactly 1 clock between commands.
  - Required: the first transfer still carries 0x1234.
- 5. Reset mid-frame: assert rst_n=0 during the DATA state of frame 0 -> tx=1 asynchronously (before the next clk edge) and cmd_rdy=1.
  - After release, a new command 0x00FF transmits cleanly from its start bit.
- 6. Default parameters (50 MHz / 115200) -> measured bit width is 434 clocks, and PARITY=0 frames are 10 bits long.
